// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the byte width used by
// tx_module/rx_module, the arbiter state encoding and the default watchdog
// limit for a transmitter that never reports completion.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W = 8;

   // Clock and baud settings shared with tx_module/rx_module.
   localparam int SYS_CLK_HZ     = 50_000_000;
   localparam int UART_BAUD      = 115_200;
   localparam int UART_BAUD_DIV  = SYS_CLK_HZ / UART_BAUD;
   // Start + 8 data + stop bits.
   localparam int UART_FRAME_CYC = 10 * UART_BAUD_DIV;

   // Allow 16 frame times before declaring the transmitter stuck, clamped so
   // the limit still fits the default 16-bit watchdog counter.
   localparam int UART_TIMEOUT_CYC =
      (16 * UART_FRAME_CYC > 65535) ? 65535 : 16 * UART_FRAME_CYC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req upward from ptr+1 with
// wrap-around and returns the first set bit, both one-hot and as an index.
// Ports:
//   req  in  N_REQ  request vector
//   ptr  in  ID_W   index of the last granted requester
//   gnt  out N_REQ  one-hot grant (all zero when req is zero)
//   idx  out ID_W   index of the granted requester (0 when req is zero)
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx
);

   logic found;
   int   k;

   // NOTE: every variable assigned in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      // Offsets 1..N_REQ visit ptr+1 first and ptr itself last.
      for (int i = 1; i <= N_REQ; i++) begin
         k = (int'(ptr) + i) % N_REQ;
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = ID_W'(k);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one tx_module between N_REQ byte requesters using round-robin
// arbitration. A granted byte is held on Tx_Data with Tx_En_Sig high until
// Tx_Done_Sig (or the watchdog) ends the transfer; the requester then gets a
// one-cycle Ack, with Err alongside it if the watchdog aborted.
// Ports:
//   CLK, RST_n   clock, asynchronous active-low reset
//   Req          in  N_REQ         level request per requester
//   Req_Data     in  N_REQ*DATA_W  byte of requester k at [k*DATA_W +: DATA_W]
//   Ack          out N_REQ         one-cycle pulse when the byte is finished
//   Err          out 1             pulse with Ack when the watchdog aborted
//   Busy         out 1             high outside IDLE
//   Grant_Id     out ID_W          current or last granted requester
//   Tx_En_Sig    out 1             transfer enable to tx_module
//   Tx_Data      out DATA_W        byte to tx_module
//   Tx_Done_Sig  in  1             completion pulse from tx_module
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int N_REQ       = 4,
   parameter  int DATA_W      = UART_DATA_W,
   parameter  int TIMEOUT_CYC = UART_TIMEOUT_CYC,
   parameter  int CNT_W       = 16,
   localparam int ID_W        = $clog2(N_REQ)
) (
   input  logic                    CLK,
   input  logic                    RST_n,
   input  logic [N_REQ-1:0]        Req,
   input  logic [N_REQ*DATA_W-1:0] Req_Data,
   output logic [N_REQ-1:0]        Ack,
   output logic                    Err,
   output logic                    Busy,
   output logic [ID_W-1:0]         Grant_Id,
   output logic                    Tx_En_Sig,
   output logic [DATA_W-1:0]       Tx_Data,
   input  logic                    Tx_Done_Sig
);

   arb_state_t         state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tx_en_q, tx_en_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic [N_REQ-1:0]   pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic               timeout_hit;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req (Req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // A zero limit disables the watchdog entirely.
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      tx_en_d   = tx_en_q;
      tx_data_d = tx_data_q;
      ack_d     = '0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|Req) begin
               grant_d   = pick_idx;
               ptr_d     = pick_idx;
               cnt_d     = '0;
               tx_en_d   = 1'b1;
               state_d   = SEND;
               // One-hot AND-OR mux of the winning byte.
               tx_data_d = '0;
               for (int k = 0; k < N_REQ; k++) begin
                  if (pick_gnt[k]) tx_data_d = tx_data_d | Req_Data[k*DATA_W +: DATA_W];
               end
            end
         end
         SEND: begin
            // Done is checked first so a same-edge timeout cannot flag Err.
            if (Tx_Done_Sig) begin
               tx_en_d        = 1'b0;
               ack_d[grant_q] = 1'b1;
               state_d        = GAP;
            end else if (timeout_hit) begin
               tx_en_d        = 1'b0;
               ack_d[grant_q] = 1'b1;
               err_d          = 1'b1;
               state_d        = GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            // Req is not sampled here, so a requester dropping Req on the
            // Ack edge is never granted twice.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= IDLE;
         ptr_q     <= ID_W'(N_REQ - 1);
         grant_q   <= '0;
         cnt_q     <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign Ack       = ack_q;
   assign Err       = err_q;
   assign Busy      = busy_q;
   assign Grant_Id  = grant_q;
   assign Tx_En_Sig = tx_en_q;
   assign Tx_Data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (4 requesters, 8-bit bytes, 20-cycle
// watchdog). Inputs change and outputs are sampled 1 time unit after the
// rising clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int TOUT   = 20;

   logic                    CLK = 1'b0;
   logic                    RST_n;
   logic [N_REQ-1:0]        Req;
   logic [N_REQ*DATA_W-1:0] Req_Data;
   logic [N_REQ-1:0]        Ack;
   logic                    Err;
   logic                    Busy;
   logic [1:0]              Grant_Id;
   logic                    Tx_En_Sig;
   logic [DATA_W-1:0]       Tx_Data;
   logic                    Tx_Done_Sig;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TOUT), .CNT_W(16)
   ) dut (
      .CLK(CLK), .RST_n(RST_n), .Req(Req), .Req_Data(Req_Data), .Ack(Ack),
      .Err(Err), .Busy(Busy), .Grant_Id(Grant_Id), .Tx_En_Sig(Tx_En_Sig),
      .Tx_Data(Tx_Data), .Tx_Done_Sig(Tx_Done_Sig)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut;
      RST_n = 1'b0; Req = '0; Tx_Done_Sig = 1'b0;
      Req_Data = {8'h55, 8'hAA, 8'h3F, 8'h2E};
      tick; tick;
      RST_n = 1'b1;
      tick;
   endtask

   task automatic pulse_done;
      Tx_Done_Sig = 1'b1;
      tick;
      Tx_Done_Sig = 1'b0;
   endtask

   task automatic test_reset;
      RST_n = 1'b0; Req = '0; Tx_Done_Sig = 1'b0;
      Req_Data = {8'h55, 8'hAA, 8'h3F, 8'h2E};
      #3;
      checks++; if (Tx_En_Sig !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b exp 0", Tx_En_Sig); end
      checks++; if (Tx_Data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h exp 00", Tx_Data); end
      checks++; if (Ack !== 4'b0000 || Err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got ack=%b err=%b exp 0000/0", Ack, Err); end
      checks++; if (Busy !== 1'b0 || Grant_Id !== 2'd0) begin errors++; $display("FAIL reset_busy_grant: got busy=%b gid=%0d exp 0/0", Busy, Grant_Id); end
      tick;
      RST_n = 1'b1;
      tick;
   endtask

   task automatic test_single;
      reset_dut;
      Req = 4'b0001;
      tick;
      checks++; if (Tx_En_Sig !== 1'b1 || Tx_Data !== 8'h2E) begin errors++; $display("FAIL single_start: got en=%b data=%h exp 1/2e", Tx_En_Sig, Tx_Data); end
      checks++; if (Busy !== 1'b1 || Grant_Id !== 2'd0) begin errors++; $display("FAIL single_busy: got busy=%b gid=%0d exp 1/0", Busy, Grant_Id); end
      tick; tick; tick;
      checks++; if (Tx_En_Sig !== 1'b1 || Ack !== 4'b0000) begin errors++; $display("FAIL single_wait: got en=%b ack=%b exp 1/0000", Tx_En_Sig, Ack); end
      pulse_done;
      checks++; if (Ack !== 4'b0001 || Err !== 1'b0 || Tx_En_Sig !== 1'b0) begin errors++; $display("FAIL single_ack: got ack=%b err=%b en=%b exp 0001/0/0", Ack, Err, Tx_En_Sig); end
      Req = 4'b0000;
      tick;
      checks++; if (Ack !== 4'b0000 || Busy !== 1'b0) begin errors++; $display("FAIL single_ack_len: got ack=%b busy=%b exp 0000/0", Ack, Busy); end
      // Done while idle must be ignored.
      pulse_done;
      tick;
      checks++; if (Ack !== 4'b0000 || Busy !== 1'b0 || Tx_En_Sig !== 1'b0) begin errors++; $display("FAIL idle_done: got ack=%b busy=%b en=%b exp 0000/0/0", Ack, Busy, Tx_En_Sig); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] bytes [4];
      int id;
      bytes[0] = 8'h2E; bytes[1] = 8'h3F; bytes[2] = 8'hAA; bytes[3] = 8'h55;
      reset_dut;
      Req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         id = n % 4;
         tick;
         checks++; if (Tx_En_Sig !== 1'b1 || Grant_Id !== 2'(id) || Tx_Data !== bytes[id]) begin errors++; $display("FAIL b2b_grant%0d: got en=%b gid=%0d data=%h exp 1/%0d/%h", n, Tx_En_Sig, Grant_Id, Tx_Data, id, bytes[id]); end
         tick; tick;
         pulse_done;
         checks++; if (Ack !== 4'(1 << id) || Tx_En_Sig !== 1'b0) begin errors++; $display("FAIL b2b_ack%0d: got ack=%b en=%b exp %b/0", n, Ack, Tx_En_Sig, 4'(1 << id)); end
         tick;
         checks++; if (Tx_En_Sig !== 1'b0 || Ack !== 4'b0000 || Busy !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got en=%b ack=%b busy=%b exp 0/0000/0", n, Tx_En_Sig, Ack, Busy); end
      end
      Req = 4'b0000;
      tick; tick;
   endtask

   task automatic test_pointer_wrap;
      reset_dut;
      Req = 4'b1000;
      tick;
      checks++; if (Grant_Id !== 2'd3 || Tx_Data !== 8'h55) begin errors++; $display("FAIL wrap_first: got gid=%0d data=%h exp 3/55", Grant_Id, Tx_Data); end
      pulse_done;
      Req = 4'b1001;
      tick;
      tick;
      checks++; if (Grant_Id !== 2'd0 || Tx_Data !== 8'h2E) begin errors++; $display("FAIL wrap_to0: got gid=%0d data=%h exp 0/2e", Grant_Id, Tx_Data); end
      pulse_done;
      checks++; if (Ack !== 4'b0001) begin errors++; $display("FAIL wrap_ack0: got %b exp 0001", Ack); end
      Req = 4'b1000;
      tick;
      tick;
      checks++; if (Grant_Id !== 2'd3 || Tx_En_Sig !== 1'b1) begin errors++; $display("FAIL wrap_then3: got gid=%0d en=%b exp 3/1", Grant_Id, Tx_En_Sig); end
      pulse_done;
      Req = 4'b0000;
      tick; tick;
   endtask

   task automatic test_watchdog;
      int n;
      reset_dut;
      Req = 4'b0100;
      tick;
      n = 0;
      while (Tx_En_Sig === 1'b1 && n < 40) begin
         n++;
         tick;
      end
      checks++; if (n !== TOUT) begin errors++; $display("FAIL wd_len: got %0d cycles exp %0d", n, TOUT); end
      checks++; if (Ack !== 4'b0100 || Err !== 1'b1) begin errors++; $display("FAIL wd_abort: got ack=%b err=%b exp 0100/1", Ack, Err); end
      Req = 4'b0000;
      tick;
      checks++; if (Ack !== 4'b0000 || Err !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL wd_pulse: got ack=%b err=%b busy=%b exp 0000/0/0", Ack, Err, Busy); end
   endtask

   task automatic test_race;
      reset_dut;
      Req = 4'b0010;
      tick;
      repeat (TOUT - 1) tick;
      checks++; if (Tx_En_Sig !== 1'b1) begin errors++; $display("FAIL race_pre: got en=%b exp 1", Tx_En_Sig); end
      pulse_done;
      checks++; if (Ack !== 4'b0010 || Err !== 1'b0) begin errors++; $display("FAIL race_done_wins: got ack=%b err=%b exp 0010/0", Ack, Err); end
      Req = 4'b0000;
      tick; tick;
   endtask

   task automatic test_req_drop;
      reset_dut;
      Req = 4'b0100;
      tick;
      Req = 4'b0000;
      Req_Data = {8'h55, 8'h00, 8'h3F, 8'h2E};
      tick; tick; tick;
      checks++; if (Tx_Data !== 8'hAA || Tx_En_Sig !== 1'b1) begin errors++; $display("FAIL drop_frozen: got data=%h en=%b exp aa/1", Tx_Data, Tx_En_Sig); end
      pulse_done;
      checks++; if (Ack !== 4'b0100) begin errors++; $display("FAIL drop_ack: got %b exp 0100", Ack); end
      tick; tick;
      checks++; if (Busy !== 1'b0 || Tx_En_Sig !== 1'b0) begin errors++; $display("FAIL drop_no_regrant: got busy=%b en=%b exp 0/0", Busy, Tx_En_Sig); end
   endtask

   task automatic test_reset_mid_send;
      reset_dut;
      Req = 4'b0100;
      tick;
      checks++; if (Tx_En_Sig !== 1'b1 || Grant_Id !== 2'd2) begin errors++; $display("FAIL rst_pre: got en=%b gid=%0d exp 1/2", Tx_En_Sig, Grant_Id); end
      #2 RST_n = 1'b0;
      #1;
      checks++; if (Tx_En_Sig !== 1'b0 || Tx_Data !== 8'h00 || Busy !== 1'b0) begin errors++; $display("FAIL rst_async: got en=%b data=%h busy=%b exp 0/00/0", Tx_En_Sig, Tx_Data, Busy); end
      checks++; if (Ack !== 4'b0000 || Err !== 1'b0 || Grant_Id !== 2'd0) begin errors++; $display("FAIL rst_async_ack: got ack=%b err=%b gid=%0d exp 0000/0/0", Ack, Err, Grant_Id); end
      RST_n = 1'b1;
      Req = 4'b0101;
      tick;
      checks++; if (Grant_Id !== 2'd0 || Tx_Data !== 8'h2E || Tx_En_Sig !== 1'b1) begin errors++; $display("FAIL rst_regrant: got gid=%0d data=%h en=%b exp 0/2e/1", Grant_Id, Tx_Data, Tx_En_Sig); end
      pulse_done;
      Req = 4'b0000;
      tick; tick;
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_pointer_wrap;
      test_watchdog;
      test_race;
      test_req_drop;
      test_reset_mid_send;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
